id_ex_stage: RTL and testbench

ID/EX pipeline register with operand forwarding and load-use hazard detection for the RV32I core. It captures decoded operands and control from the decode stage and drives the execute-stage ALU's `SrcA`, `SrcB` and `Operation` inputs. Operands are resolved through EX/MEM and MEM/WB forwarding. The block asserts `stall` to the upstream IF/ID stage on a load-use hazard, and inserts bubbles on stall, flush and reset.

---
 rtl/id_ex_stage.sv | 164 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : RV32I ID/EX pipeline register with EX/MEM and MEM/WB operand
//            forwarding and load-use hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic                      id_alu_src,
    input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      flush,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0]     memwb_data,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic                      ex_valid,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      stall
);

    localparam logic [REG_ADDR_WIDTH-1:0] c_X0 = '0;

    logic                      valid_q,     valid_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q,       rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q,       rs2_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
    logic [DATA_WIDTH-1:0]     rs1_data_q,  rs1_data_d;
    logic [DATA_WIDTH-1:0]     rs2_data_q,  rs2_data_d;
    logic [DATA_WIDTH-1:0]     imm_q,       imm_d;
    logic                      alu_src_q,   alu_src_d;
    logic [OPCODE_LENGTH-1:0]  alu_op_q,    alu_op_d;
    logic                      reg_write_q, reg_write_d;
    logic                      mem_read_q,  mem_read_d;
    logic                      mem_write_q, mem_write_d;

    logic                      w_hazard;
    logic [DATA_WIDTH-1:0]     w_fwd_rs1;
    logic [DATA_WIDTH-1:0]     w_fwd_rs2;

    // A load in EX whose result is needed by the instruction in ID.
    assign w_hazard = valid_q && mem_read_q && (rd_q != c_X0) && id_valid &&
                      ((rd_q == id_rs1) || (rd_q == id_rs2));
    assign stall    = w_hazard && !flush;

    always_comb begin
        valid_d     = 1'b0;
        rs1_d       = '0;
        rs2_d       = '0;
        rd_d        = '0;
        rs1_data_d  = '0;
        rs2_data_d  = '0;
        imm_d       = '0;
        alu_src_d   = 1'b0;
        alu_op_d    = '0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        if (!flush && !w_hazard && id_valid) begin
            valid_d     = 1'b1;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            alu_src_d   = id_alu_src;
            alu_op_d    = id_alu_op;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            alu_op_q    <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            alu_src_q   <= alu_src_d;
            alu_op_q    <= alu_op_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards.
    function automatic logic [DATA_WIDTH-1:0] fwd(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0]     rf_val,
        input logic                      em_we,
        input logic [REG_ADDR_WIDTH-1:0] em_rd,
        input logic [DATA_WIDTH-1:0]     em_val,
        input logic                      mw_we,
        input logic [REG_ADDR_WIDTH-1:0] mw_rd,
        input logic [DATA_WIDTH-1:0]     mw_val
    );
        if (em_we && (em_rd != c_X0) && (em_rd == rs))
            return em_val;
        else if (mw_we && (mw_rd != c_X0) && (mw_rd == rs))
            return mw_val;
        else
            return rf_val;
    endfunction

    assign w_fwd_rs1 = fwd(rs1_q, rs1_data_q, exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_data);
    assign w_fwd_rs2 = fwd(rs2_q, rs2_data_q, exmem_reg_write, exmem_rd, exmem_result,
                           memwb_reg_write, memwb_rd, memwb_data);

    assign SrcA          = w_fwd_rs1;
    assign SrcB          = alu_src_q ? imm_q : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign Operation     = alu_op_q;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Scoreboard bench for id_ex_stage: directed scenarios followed by
//            randomized traffic against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_alu_op;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_data;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [3:0]  Operation;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;
    logic        stall;

    id_ex_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .stall(stall)
    );

    always #5 clk = ~clk;

    // The instruction the model believes is sitting in EX.
    typedef struct {
        bit        v;
        bit [4:0]  rs1, rs2, rd;
        bit [31:0] d1, d2, imm;
        bit        src;
        bit [3:0]  op;
        bit        rw, mr, mw;
    } instr_t;

    typedef struct {
        bit [31:0] srca, srcb, store;
        bit [3:0]  op;
        bit        v, rw, mr, mw, stall;
        bit [4:0]  rd;
    } exp_t;

    instr_t ex_m, ex_next;
    exp_t   sb_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     prev_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] ref_operand(input bit [4:0] rs, input bit [31:0] regval);
        if (rs == 0) return regval;
        if (exmem_reg_write && exmem_rd == rs) return exmem_result;
        if (memwb_reg_write && memwb_rd == rs) return memwb_data;
        return regval;
    endfunction

    // Compute this cycle's expected outputs from the model, then the next EX content.
    task automatic settle();
        exp_t   e;
        instr_t cap;
        bit     load_use;
        e.srca  = ref_operand(ex_m.rs1, ex_m.d1);
        e.store = ref_operand(ex_m.rs2, ex_m.d2);
        e.srcb  = ex_m.src ? ex_m.imm : e.store;
        e.op    = ex_m.op;
        e.v     = ex_m.v;
        e.rd    = ex_m.rd;
        e.rw    = ex_m.rw;
        e.mr    = ex_m.mr;
        e.mw    = ex_m.mw;
        load_use = ex_m.v && ex_m.mr && ex_m.rd != 0 && id_valid &&
                   (ex_m.rd == id_rs1 || ex_m.rd == id_rs2);
        e.stall = load_use && !flush;
        prev_stall = e.stall;
        sb_q.push_back(e);
        cap = '{default: 0};
        if (!reset && !flush && !load_use && id_valid) begin
            cap = '{v: 1, rs1: id_rs1, rs2: id_rs2, rd: id_rd, d1: id_rs1_data,
                    d2: id_rs2_data, imm: id_imm, src: id_alu_src, op: id_alu_op,
                    rw: id_reg_write, mr: id_mem_read, mw: id_mem_write};
        end
        ex_next = cap;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        ex_m = ex_next;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    // Monitor: the block presents a full set of outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("SrcA",          SrcA,          e.srca);
                chk("SrcB",          SrcB,          e.srcb);
                chk("ex_store_data", ex_store_data, e.store);
                chk("Operation",     {28'd0, Operation}, {28'd0, e.op});
                chk("ex_valid",      {31'd0, ex_valid},     {31'd0, e.v});
                chk("ex_rd",         {27'd0, ex_rd},        {27'd0, e.rd});
                chk("ex_reg_write",  {31'd0, ex_reg_write}, {31'd0, e.rw});
                chk("ex_mem_read",   {31'd0, ex_mem_read},  {31'd0, e.mr});
                chk("ex_mem_write",  {31'd0, ex_mem_write}, {31'd0, e.mw});
                chk("stall",         {31'd0, stall},        {31'd0, e.stall});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic set_id(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd,
                          input bit [31:0] d1, input bit [31:0] d2, input bit [3:0] op,
                          input bit mr);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_alu_op = op;
        id_alu_src = 0; id_imm = 32'h0; id_reg_write = 1; id_mem_read = mr; id_mem_write = 0;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    initial begin
        reset = 1; flush = 0;
        set_id(1, 5'd1, 5'd2, 5'd9, 32'h1111, 32'h2222, 4'h7, 0);
        no_fwd();
        @(posedge clk); #1;
        ex_m = '{default: 0};

        // Reset held for two cycles with a valid instruction offered.
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
            chk("rst_Operation", {28'd0, Operation}, 32'd0);
            chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
            chk("rst_stall", {31'd0, stall}, 32'd0);
            advance();
        end
        reset = 0;

        // Plain capture.
        set_id(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 4'b0010, 0);
        step();
        id_valid = 0;
        settle();
        chk("cap_SrcA", SrcA, 32'd5);
        chk("cap_SrcB", SrcB, 32'd7);
        chk("cap_Operation", {28'd0, Operation}, 32'd2);
        chk("cap_ex_rd", {27'd0, ex_rd}, 32'd3);
        chk("cap_ex_valid", {31'd0, ex_valid}, 32'd1);
        advance();

        // Forwarding priority on rs1 = 4.
        set_id(1, 5'd4, 5'd0, 5'd8, 32'h11, 32'h0, 4'h1, 0);
        step();
        exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 4; memwb_data = 32'hBB;
        settle();
        chk("fwd_exmem_SrcA", SrcA, 32'hAA);
        advance();
        exmem_reg_write = 0;
        settle();
        chk("fwd_memwb_SrcA", SrcA, 32'hBB);
        advance();

        // x0 never forwards.
        no_fwd();
        set_id(1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 4'h1, 0);
        step();
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'h55;
        id_valid = 0;
        settle();
        chk("x0_SrcA", SrcA, 32'h0);
        advance();
        no_fwd();

        // Load-use: load to x6 in EX, ID reads x6 through rs2.
        set_id(1, 5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 4'h0, 1);
        step();
        set_id(1, 5'd1, 5'd6, 5'd7, 32'h3, 32'h4, 4'h3, 0);
        settle();
        chk("lu_stall", {31'd0, stall}, 32'd1);
        advance();
        settle();
        chk("lu_stall_clear", {31'd0, stall}, 32'd0);
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        advance();
        id_valid = 0;
        settle();
        chk("lu_capture_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_capture_rd", {27'd0, ex_rd}, 32'd7);
        advance();

        // Flush with a hazard present, then an immediate-operand capture.
        set_id(1, 5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 4'h0, 1);
        step();
        set_id(1, 5'd6, 5'd2, 5'd7, 32'h3, 32'h4, 4'h3, 0);
        flush = 1;
        settle();
        chk("fl_stall", {31'd0, stall}, 32'd0);
        advance();
        flush = 0;
        set_id(1, 5'd1, 5'd2, 5'd10, 32'h9, 32'h1234, 4'h4, 0);
        id_alu_src = 1; id_imm = 32'hFFFFFFF0;
        settle();
        chk("fl_bubble", {31'd0, ex_valid}, 32'd0);
        advance();
        id_valid = 0;
        settle();
        chk("imm_SrcB", SrcB, 32'hFFFFFFF0);
        chk("imm_store", ex_store_data, 32'h1234);
        advance();

        // Reset mid-stall.
        set_id(1, 5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 4'h0, 1);
        step();
        set_id(1, 5'd6, 5'd2, 5'd7, 32'h3, 32'h4, 4'h3, 0);
        reset = 1;
        settle();
        chk("rs_stall_hold", {31'd0, stall}, 32'd1);
        advance();
        reset = 0;
        settle();
        chk("rs_stall_drop", {31'd0, stall}, 32'd0);
        chk("rs_bubble", {31'd0, ex_valid}, 32'd0);
        advance();

        // Randomized traffic; ID holds its instruction while stalled.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 7) == 0);
            if (!prev_stall) begin
                id_valid     = ($urandom_range(0, 3) != 0);
                id_rs1       = 5'($urandom_range(0, 7));
                id_rs2       = 5'($urandom_range(0, 7));
                id_rd        = 5'($urandom_range(0, 7));
                id_rs1_data  = $urandom;
                id_rs2_data  = $urandom;
                id_imm       = $urandom;
                id_alu_src   = 1'($urandom_range(0, 1));
                id_alu_op    = 4'($urandom_range(0, 15));
                id_reg_write = 1'($urandom_range(0, 1));
                id_mem_read  = ($urandom_range(0, 2) == 0);
                id_mem_write = 1'($urandom_range(0, 1));
            end
            exmem_reg_write = 1'($urandom_range(0, 1));
            exmem_rd        = 5'($urandom_range(0, 7));
            exmem_result    = $urandom;
            memwb_reg_write = 1'($urandom_range(0, 1));
            memwb_rd        = 5'($urandom_range(0, 7));
            memwb_data      = $urandom;
            step();
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
